// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the alarm sequencer, the watch/setting logic and sound_control.
// The master side drives time, enable and button inputs; the slave side is the sequencer.
interface alarm_sequencer_if;
  logic       tick_sec;
  logic       bud_en;
  logic [3:0] hourdec_now;
  logic [3:0] hourone_now;
  logic [3:0] mindec_now;
  logic [3:0] minone_now;
  logic [3:0] hourdec_bud;
  logic [3:0] hourone_bud;
  logic [3:0] mindec_bud;
  logic [3:0] minone_bud;
  logic       btn_snooze;
  logic       btn_stop;
  logic       bud_on;
  logic [1:0] state_o;
  logic [2:0] snooze_left;

  modport master (
    output tick_sec, bud_en,
    output hourdec_now, hourone_now, mindec_now, minone_now,
    output hourdec_bud, hourone_bud, mindec_bud, minone_bud,
    output btn_snooze, btn_stop,
    input  bud_on, state_o, snooze_left
  );

  modport slave (
    input  tick_sec, bud_en,
    input  hourdec_now, hourone_now, mindec_now, minone_now,
    input  hourdec_bud, hourone_bud, mindec_bud, minone_bud,
    input  btn_snooze, btn_stop,
    output bud_on, state_o, snooze_left
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: fires on the rising edge of a now/alarm time match and runs the
// ring / snooze / stop cycle, counting seconds from the tick_sec enable.
module alarm_sequencer #(
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_S       = 300,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic              clk,
  input  logic              rst,
  alarm_sequencer_if.slave  bus
);

  localparam int unsigned MAX_T = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int unsigned CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    RING   = 2'b10,
    SNOOZE = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [2:0]       snooze_left_q, snooze_left_d;
  logic             bud_on_q, bud_on_d;
  logic             match_q;

  logic match_c, trig_c, ring_to_c, snooze_to_c, has_snooze_c;

  // Raw 16-bit compare; invalid BCD is deliberately not filtered.
  assign match_c = ({bus.hourdec_now, bus.hourone_now, bus.mindec_now, bus.minone_now} ==
                    {bus.hourdec_bud, bus.hourone_bud, bus.mindec_bud, bus.minone_bud});
  assign trig_c       = match_c & ~match_q;
  assign ring_to_c    = bus.tick_sec & (sec_cnt_q == CNT_W'(RING_TIMEOUT_S - 1));
  assign snooze_to_c  = bus.tick_sec & (sec_cnt_q == CNT_W'(SNOOZE_S - 1));
  assign has_snooze_c = (snooze_left_q != 3'd0);

  // Match history is held clear while IDLE, so a match already present when the block
  // arms (for example straight after reset) still produces a rising edge and fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= (state_q == IDLE) ? 1'b0 : match_c;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; disable outranks stop, stop outranks snooze, snooze outranks timeout.
  always_comb begin
    state_d = state_q;
    if (!bus.bud_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (trig_c) begin
            state_d = RING;
          end
        end
        RING: begin
          if (bus.btn_stop) begin
            state_d = ARMED;
          end else if (bus.btn_snooze && has_snooze_c) begin
            state_d = SNOOZE;
          end else if (ring_to_c) begin
            state_d = has_snooze_c ? SNOOZE : ARMED;
          end
        end
        SNOOZE: begin
          if (bus.btn_stop) begin
            state_d = ARMED;
          end else if (snooze_to_c) begin
            state_d = RING;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output/datapath next values, derived from the current and next state.
  always_comb begin
    sec_cnt_d     = sec_cnt_q;
    snooze_left_d = snooze_left_q;
    // Ring request starts the clk after RING entry and drops together with RING exit.
    bud_on_d      = (state_q == RING) && (state_d == RING);

    if ((state_d != state_q) && ((state_d == RING) || (state_d == SNOOZE))) begin
      sec_cnt_d = '0;
    end else if (((state_q == RING) || (state_q == SNOOZE)) && (state_d == state_q) &&
                 bus.tick_sec) begin
      sec_cnt_d = sec_cnt_q + CNT_W'(1);
    end

    if ((state_q == ARMED) && (state_d == RING)) begin
      snooze_left_d = 3'(MAX_SNOOZE);
    end else if ((state_q == RING) && (state_d == SNOOZE)) begin
      snooze_left_d = snooze_left_q - 3'd1;
    end
  end

  // Registered outputs and second counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt_q     <= '0;
      snooze_left_q <= 3'(MAX_SNOOZE);
      bud_on_q      <= 1'b0;
    end else begin
      sec_cnt_q     <= sec_cnt_d;
      snooze_left_q <= snooze_left_d;
      bud_on_q      <= bud_on_d;
    end
  end

  assign bus.bud_on      = bud_on_q;
  assign bus.state_o     = state_q;
  assign bus.snooze_left = snooze_left_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with the default 60 s ring, 300 s snooze, 3 snoozes.
module tb_alarm_sequencer;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ARMED  = 2'b01;
  localparam logic [1:0] ST_RING   = 2'b10;
  localparam logic [1:0] ST_SNOOZE = 2'b11;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  alarm_sequencer_if bus ();

  alarm_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "bench did not terminate");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_sec = 1'b1;
      step();
      bus.tick_sec = 1'b0;
      step();
    end
  endtask

  task automatic set_now(input logic [15:0] t);
    {bus.hourdec_now, bus.hourone_now, bus.mindec_now, bus.minone_now} = t;
  endtask

  task automatic set_bud(input logic [15:0] t);
    {bus.hourdec_bud, bus.hourone_bud, bus.mindec_bud, bus.minone_bud} = t;
  endtask

  task automatic press(input logic stop, input logic snooze);
    bus.btn_stop   = stop;
    bus.btn_snooze = snooze;
    step();
    bus.btn_stop   = 1'b0;
    bus.btn_snooze = 1'b0;
  endtask

  // Creates a fresh rising edge of the 07:30 match.
  task automatic refire();
    set_now(16'h0731);
    step();
    set_now(16'h0730);
    step();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    bus.tick_sec   = 1'b0;
    bus.bud_en     = 1'b1;
    bus.btn_snooze = 1'b0;
    bus.btn_stop   = 1'b0;
    set_bud(16'h0730);
    set_now(16'h0729);
    step();
    step();

    // Reset state
    chk("rst_state", 16'(bus.state_o), 16'(ST_IDLE));
    chk("rst_bud_on", 16'(bus.bud_on), 16'd0);
    chk("rst_snooze_left", 16'(bus.snooze_left), 16'd3);
    rst = 1'b0;
    chk("rel_idle", 16'(bus.state_o), 16'(ST_IDLE));
    step();
    chk("armed", 16'(bus.state_o), 16'(ST_ARMED));

    // 1: 07:29 -> 07:30 fires, bud_on two clk after the match
    set_now(16'h0730);
    step();
    chk("t1_ring", 16'(bus.state_o), 16'(ST_RING));
    chk("t1_bud_on_lag", 16'(bus.bud_on), 16'd0);
    chk("t1_snooze_left", 16'(bus.snooze_left), 16'd3);
    step();
    chk("t1_bud_on", 16'(bus.bud_on), 16'd1);
    tick_n(59);
    chk("t1_ring_59", 16'(bus.state_o), 16'(ST_RING));
    chk("t1_bud_on_59", 16'(bus.bud_on), 16'd1);

    // 2: manual snooze, 300 s silence, ring again, stop without re-fire
    press(1'b0, 1'b1);
    chk("t2_snooze", 16'(bus.state_o), 16'(ST_SNOOZE));
    chk("t2_snooze_left", 16'(bus.snooze_left), 16'd2);
    chk("t2_bud_off", 16'(bus.bud_on), 16'd0);
    press(1'b0, 1'b1);
    chk("t2_snooze_ign", 16'(bus.state_o), 16'(ST_SNOOZE));
    chk("t2_snooze_left_ign", 16'(bus.snooze_left), 16'd2);
    tick_n(299);
    chk("t2_snooze_299", 16'(bus.state_o), 16'(ST_SNOOZE));
    tick_n(1);
    chk("t2_ring_again", 16'(bus.state_o), 16'(ST_RING));
    chk("t2_bud_on_again", 16'(bus.bud_on), 16'd1);
    press(1'b1, 1'b0);
    chk("t2_stop", 16'(bus.state_o), 16'(ST_ARMED));
    chk("t2_stop_bud", 16'(bus.bud_on), 16'd0);
    for (int i = 0; i < 5; i++) step();
    chk("t2_no_refire", 16'(bus.state_o), 16'(ST_ARMED));

    // 3: three automatic snoozes, then the 4th timeout stops
    refire();
    chk("t3_ring", 16'(bus.state_o), 16'(ST_RING));
    chk("t3_snooze_left", 16'(bus.snooze_left), 16'd3);
    for (int k = 1; k <= 3; k++) begin
      tick_n(59);
      chk("t3_ring_59", 16'(bus.state_o), 16'(ST_RING));
      tick_n(1);
      chk("t3_auto_snooze", 16'(bus.state_o), 16'(ST_SNOOZE));
      chk("t3_left", 16'(bus.snooze_left), 16'(3 - k));
      chk("t3_bud_off", 16'(bus.bud_on), 16'd0);
      tick_n(299);
      chk("t3_snooze_299", 16'(bus.state_o), 16'(ST_SNOOZE));
      tick_n(1);
      chk("t3_ring_back", 16'(bus.state_o), 16'(ST_RING));
    end
    press(1'b0, 1'b1);
    chk("t3_snooze_exh", 16'(bus.state_o), 16'(ST_RING));
    chk("t3_snooze_exh_bud", 16'(bus.bud_on), 16'd1);
    tick_n(59);
    chk("t3_ring_last", 16'(bus.state_o), 16'(ST_RING));
    tick_n(1);
    chk("t3_final_armed", 16'(bus.state_o), 16'(ST_ARMED));
    chk("t3_final_left", 16'(bus.snooze_left), 16'd0);
    chk("t3_final_bud", 16'(bus.bud_on), 16'd0);

    // 4: stop beats snooze; disable during SNOOZE goes IDLE next clk
    refire();
    chk("t4_ring", 16'(bus.state_o), 16'(ST_RING));
    press(1'b1, 1'b1);
    chk("t4_stop_wins", 16'(bus.state_o), 16'(ST_ARMED));
    chk("t4_left_kept", 16'(bus.snooze_left), 16'd3);
    refire();
    press(1'b0, 1'b1);
    chk("t4_snooze", 16'(bus.state_o), 16'(ST_SNOOZE));
    bus.bud_en = 1'b0;
    step();
    chk("t4_idle", 16'(bus.state_o), 16'(ST_IDLE));
    chk("t4_idle_bud", 16'(bus.bud_on), 16'd0);

    // 5: reset mid-RING, then re-fire on the still-matching time
    set_now(16'h0731);
    bus.bud_en = 1'b1;
    step();
    chk("t5_armed", 16'(bus.state_o), 16'(ST_ARMED));
    set_now(16'h0730);
    step();
    step();
    chk("t5_bud_on", 16'(bus.bud_on), 16'd1);
    tick_n(3);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_bud", 16'(bus.bud_on), 16'd0);
    chk("t5_async_state", 16'(bus.state_o), 16'(ST_IDLE));
    chk("t5_async_left", 16'(bus.snooze_left), 16'd3);
    step();
    rst = 1'b0;
    chk("t5_rel_idle", 16'(bus.state_o), 16'(ST_IDLE));
    step();
    chk("t5_rel_armed", 16'(bus.state_o), 16'(ST_ARMED));
    step();
    chk("t5_refire", 16'(bus.state_o), 16'(ST_RING));
    step();
    chk("t5_refire_bud", 16'(bus.bud_on), 16'd1);

    // 6: alarm edited onto current minute fires; disabled match does not ring
    press(1'b1, 1'b0);
    set_bud(16'h0800);
    set_now(16'h0745);
    step();
    step();
    chk("t6_armed", 16'(bus.state_o), 16'(ST_ARMED));
    set_bud(16'h0745);
    step();
    chk("t6_edit_fire", 16'(bus.state_o), 16'(ST_RING));
    press(1'b1, 1'b0);
    bus.bud_en = 1'b0;
    step();
    chk("t6_idle", 16'(bus.state_o), 16'(ST_IDLE));
    set_now(16'h0746);
    step();
    set_now(16'h0745);
    step();
    step();
    chk("t6_idle_match", 16'(bus.state_o), 16'(ST_IDLE));
    chk("t6_idle_bud", 16'(bus.bud_on), 16'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
